// File: rtl/msfsm_handshake_io_adapter.sv
// Boundary stage between the asynchronous handshake environment and the MSFSM array.
// Optional sticky protocol checking is enabled by defining MSFSM_IO_PROTOCOL_CHECK_EN.
module msfsm_handshake_io_adapter #(
  parameter int                N_IN        = 2,
  parameter int                N_OUT       = 2,
  parameter int                SYNC_STAGES = 2,
  parameter logic [N_IN-1:0]   IN_INIT     = '0,
  parameter logic [N_OUT-1:0]  OUT_INIT    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  in_async_i,
  output logic [N_IN-1:0]  in_plus_o,
  output logic [N_IN-1:0]  in_minus_o,
  output logic             ready_o,
  input  logic [N_OUT-1:0] evt_plus_i,
  input  logic [N_OUT-1:0] evt_minus_i,
`ifdef MSFSM_IO_PROTOCOL_CHECK_EN
  output logic             err_o,
  output logic [N_OUT-1:0] err_vec_o,
`endif
  output logic [N_OUT-1:0] out_lvl_o
);

  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_STAGES);

  logic [N_IN-1:0]  syncChain_q [SYNC_STAGES];
  logic [CW-1:0]    warmCnt_q;
  logic [CW-1:0]    warmCnt_d;
  logic [N_OUT-1:0] outLvl_q;
  logic [N_OUT-1:0] outLvl_d;
  logic             readyInt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        syncChain_q[k] <= IN_INIT;
      end
      warmCnt_q <= '0;
      outLvl_q  <= OUT_INIT;
    end else begin
      syncChain_q[0] <= in_async_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        syncChain_q[k] <= syncChain_q[k-1];
      end
      warmCnt_q <= warmCnt_d;
      outLvl_q  <= outLvl_d;
    end
  end

  // Counter saturates so ready stays high until the next reset.
  always_comb begin
    warmCnt_d = warmCnt_q;
    if (warmCnt_q != CNT_MAX) begin
      warmCnt_d = warmCnt_q + CW'(1);
    end
  end

  assign readyInt = (warmCnt_q == CNT_MAX);

  // Conflicting or absent strobes leave the level untouched.
  always_comb begin
    outLvl_d = outLvl_q;
    for (int j = 0; j < N_OUT; j++) begin
      if (evt_plus_i[j] && !evt_minus_i[j]) begin
        outLvl_d[j] = 1'b1;
      end else if (evt_minus_i[j] && !evt_plus_i[j]) begin
        outLvl_d[j] = 1'b0;
      end
    end
  end

  assign ready_o    = readyInt;
  assign in_plus_o  = readyInt ? syncChain_q[SYNC_STAGES-1]  : '0;
  assign in_minus_o = readyInt ? ~syncChain_q[SYNC_STAGES-1] : '0;
  assign out_lvl_o  = outLvl_q;

`ifdef MSFSM_IO_PROTOCOL_CHECK_EN
  logic [N_OUT-1:0] errVec_q;
  logic [N_OUT-1:0] errVec_d;
  logic             consistErr_q;
  logic             consistErr_d;

  // Double strobes and redundant strobes are both flagged, sticky until reset.
  always_comb begin
    errVec_d     = errVec_q | (evt_plus_i & evt_minus_i)
                            | (evt_plus_i & outLvl_q)
                            | (evt_minus_i & ~outLvl_q);
    consistErr_d = consistErr_q | (readyInt && |(in_plus_o & in_minus_o));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      errVec_q     <= '0;
      consistErr_q <= 1'b0;
    end else begin
      errVec_q     <= errVec_d;
      consistErr_q <= consistErr_d;
    end
  end

  assign err_vec_o = errVec_q;
  assign err_o     = consistErr_q | (|errVec_q);
`endif

endmodule

// File: tb/tb_msfsm_handshake_io_adapter.sv
// Table-driven bench for msfsm_handshake_io_adapter (N_IN=N_OUT=2, SYNC_STAGES=2, inits 0).
// Error outputs are checked only when MSFSM_IO_PROTOCOL_CHECK_EN is defined.
module tb_msfsm_handshake_io_adapter;

  logic       clk;
  logic       reset;
  logic [1:0] inAsync;
  logic [1:0] inPlus;
  logic [1:0] inMinus;
  logic       ready;
  logic [1:0] evtPlus;
  logic [1:0] evtMinus;
  logic [1:0] outLvl;
`ifdef MSFSM_IO_PROTOCOL_CHECK_EN
  logic       err;
  logic [1:0] errVec;
`endif

  int testsRun;
  int testsFailed;

  msfsm_handshake_io_adapter #(
    .N_IN(2), .N_OUT(2), .SYNC_STAGES(2), .IN_INIT(2'b00), .OUT_INIT(2'b00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_async_i(inAsync),
    .in_plus_o(inPlus),
    .in_minus_o(inMinus),
    .ready_o(ready),
    .evt_plus_i(evtPlus),
    .evt_minus_i(evtMinus),
`ifdef MSFSM_IO_PROTOCOL_CHECK_EN
    .err_o(err),
    .err_vec_o(errVec),
`endif
    .out_lvl_o(outLvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] inA;
    logic [1:0] ep;
    logic [1:0] em;
    logic [1:0] expPlus;
    logic [1:0] expMinus;
    logic       expReady;
    logic [1:0] expOut;
    logic       expErr;
    logic [1:0] expErrVec;
  } vec_t;

  vec_t vecs [17];

  task automatic checkOutput(input string name, input int idx,
                             input logic [1:0] actual, input logic [1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s vec %0d: got %b expected %b", name, idx, actual, expected);
    end
  endtask

  // Drive one vector, clock it in, then sample just after the edge.
  task automatic applyStimulus(input vec_t v);
    reset    = v.rst;
    inAsync  = v.inA;
    evtPlus  = v.ep;
    evtMinus = v.em;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    testsRun    = 0;
    testsFailed = 0;
    reset    = 1'b1;
    inAsync  = 2'b00;
    evtPlus  = 2'b00;
    evtMinus = 2'b00;

    //          rst  in     ep     em     plus   minus  rdy   out    err   errVec
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[1]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[2]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00};
    vecs[3]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00};
    vecs[5]  = '{1'b0, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 1'b1, 2'b10, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 1'b1, 2'b10, 1'b0, 2'b00};
    vecs[7]  = '{1'b0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00};
    vecs[8]  = '{1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 1'b1, 2'b00, 1'b1, 2'b01};
    vecs[9]  = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1, 2'b01, 1'b1, 2'b01};
    vecs[10] = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1, 2'b01, 1'b1, 2'b01};
    vecs[11] = '{1'b0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 1'b1, 2'b11, 1'b1, 2'b01};
    vecs[12] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 2'b11, 1'b1, 2'b01};
    vecs[13] = '{1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[14] = '{1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00};
    vecs[15] = '{1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00};
    vecs[16] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00};

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      checkOutput("in_plus", i, inPlus, vecs[i].expPlus);
      checkOutput("in_minus", i, inMinus, vecs[i].expMinus);
      checkOutput("ready", i, {1'b0, ready}, {1'b0, vecs[i].expReady});
      checkOutput("out_lvl", i, outLvl, vecs[i].expOut);
`ifdef MSFSM_IO_PROTOCOL_CHECK_EN
      checkOutput("err", i, {1'b0, err}, {1'b0, vecs[i].expErr});
      checkOutput("err_vec", i, errVec, vecs[i].expErrVec);
`endif
    end

    // Input latency: a rising edge on input 1 must take exactly two clock edges.
    inAsync = 2'b10;
    edges = 0;
    while (inPlus[1] !== 1'b1 && edges < 6) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("latency_in1", 17, 2'(edges), 2'd2);
    checkOutput("in_minus_in1", 17, inMinus, 2'b01);

    // Mid-handshake reset with both levels high drops everything back to idle.
    evtPlus = 2'b11;
    @(posedge clk);
    #1;
    evtPlus = 2'b00;
    checkOutput("out_lvl_pre", 18, outLvl, 2'b11);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("out_lvl_rst", 19, outLvl, 2'b00);
    checkOutput("ready_rst", 19, {1'b0, ready}, 2'b00);
    checkOutput("in_plus_rst", 19, inPlus, 2'b00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
